// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle CPU sequencer; owns state, memory handshake, condition skip, retire count
// clk/rst_n: clock and async active-low reset
// op, funct, rd, cond_ex, no_write: instruction fields and decoder/condition flags
// mem_ready: memory completes the current request this cycle
// mem_req..alu_op: datapath control strobes; illegal: sticky op=11 flag
// retired: wrapping retired-instruction count; state_o: current state code
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic [3:0]       rd,
  input  logic             cond_ex,
  input  logic             no_write,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             ir_write,
  output logic             next_pc,
  output logic             branch,
  output logic             pc_wb,
  output logic             reg_w,
  output logic             mem_w,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic             alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4, MEMWB = 4'd5,
    MEMWR = 4'd6, EXER = 4'd7, EXEI = 4'd8, ALUWB = 4'd9, BRANCH = 4'd10
  } state_t;
  state_t state, state_nx;
  logic retire;
  logic unused_funct;
  assign unused_funct = ^funct[4:1];
  assign state_o = state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE && op == 2'b11) illegal <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end
  always_comb begin
    state_nx   = IDLE;
    retire     = 1'b0;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    branch     = 1'b0;
    pc_wb      = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 1'b0;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        next_pc    = mem_ready;
        state_nx   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // illegal opcode outranks the condition check and does not retire
        if (op == 2'b11) state_nx = FETCH;
        else if (!cond_ex) begin
          state_nx = FETCH;
          retire   = 1'b1;
        end
        else if (op == 2'b01) state_nx = MEMADR;
        else if (op == 2'b10) state_nx = BRANCH;
        else state_nx = funct[5] ? EXEI : EXER;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b01;
        state_nx  = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req  = 1'b1;
        adr_src  = 1'b1;
        state_nx = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_w      = 1'b1;
        result_src = 2'b01;
        pc_wb      = rd == 4'hf;
        state_nx   = FETCH;
        retire     = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        mem_w    = 1'b1;
        adr_src  = 1'b1;
        state_nx = mem_ready ? FETCH : MEMWR;
        retire   = mem_ready;
      end
      EXER, EXEI: begin
        alu_src_a = 1'b1;
        alu_src_b = state == EXEI ? 2'b01 : 2'b00;
        alu_op    = 1'b1;
        state_nx  = no_write ? FETCH : ALUWB;
        retire    = no_write;
      end
      ALUWB: begin
        reg_w    = 1'b1;
        pc_wb    = rd == 4'hf;
        state_nx = FETCH;
        retire   = 1'b1;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        state_nx   = FETCH;
        retire     = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
